// File: rtl/maze_tile_blitter.sv
// Turns fill-tile / clear-screen commands into single-pixel SRAM writes.
// Ports: cmd_* in (valid/ready), sram_wr_* out (ready back), busy/done/err status.
module maze_tile_blitter #(
  parameter int H_RES  = 800,
  parameter int V_RES  = 600,
  parameter int TILE_W = 20,
  parameter int TILE_H = 20,
  parameter int GRID_W = 40,
  parameter int GRID_H = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [5:0]  cmd_col,
  input  logic [4:0]  cmd_row,
  input  logic [23:0] cmd_color,
  output logic        sram_wr_en,
  output logic [19:0] sram_wr_addr,
  output logic [31:0] sram_wr_data,
  input  logic        sram_wr_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_WRITE,
    S_FINISH
  } state_e;

  localparam logic [19:0] ROW_STEP = 20'(TILE_H * H_RES);
  localparam logic [19:0] COL_STEP = 20'(TILE_W);
  localparam logic [19:0] PITCH    = 20'(H_RES);

  state_e      state_q, state_d;
  logic        op_q, op_d;
  logic [5:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [23:0] color_q, color_d;
  logic [19:0] addr_q, addr_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        err_q, err_d;

  logic [9:0]  span_w;
  logic [9:0]  span_h;
  logic [19:0] base;

  assign span_w = op_q ? 10'(H_RES) : 10'(TILE_W);
  assign span_h = op_q ? 10'(V_RES) : 10'(TILE_H);
  // Constant multiplies, evaluated once per command in SETUP.
  assign base = 20'(row_q) * ROW_STEP + 20'(col_q) * COL_STEP;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    col_d   = col_q;
    row_d   = row_q;
    color_d = color_q;
    addr_d  = addr_q;
    x_d     = x_q;
    y_d     = y_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          col_d   = cmd_col;
          row_d   = cmd_row;
          color_d = cmd_color;
          x_d     = '0;
          y_d     = '0;
          err_d   = 1'b0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (op_q) begin
          addr_d  = '0;
          color_d = '0;
          state_d = S_WRITE;
        end else if (col_q >= 6'(GRID_W) ||
                     row_q >= 5'(GRID_H)) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          addr_d  = base;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (sram_wr_ready) begin
          if (x_q == span_w - 10'd1) begin
            x_d = '0;
            if (y_q == span_h - 10'd1) begin
              state_d = S_FINISH;
            end else begin
              y_d    = y_q + 10'd1;
              // Jump to the first pixel of the next line of the span.
              addr_d = addr_q + PITCH - 20'(span_w) + 20'd1;
            end
          end else begin
            x_d    = x_q + 10'd1;
            addr_d = addr_q + 20'd1;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      color_q <= '0;
      addr_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      col_q   <= col_d;
      row_q   <= row_d;
      color_q <= color_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign sram_wr_en   = (state_q == S_WRITE);
  assign sram_wr_addr = addr_q;
  assign sram_wr_data = {8'h00, color_q};
  assign done         = (state_q == S_FINISH);
  assign err          = (state_q == S_FINISH) && err_q;

endmodule

// File: tb/tb_maze_tile_blitter.sv
// Directed bench for maze_tile_blitter.
// Records accepted writes per command and checks them against hand-derived values.
module tb_maze_tile_blitter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [5:0]  cmd_col;
  logic [4:0]  cmd_row;
  logic [23:0] cmd_color;
  logic        sram_wr_en;
  logic [19:0] sram_wr_addr;
  logic [31:0] sram_wr_data;
  logic        sram_wr_ready;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  maze_tile_blitter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_col      (cmd_col),
    .cmd_row      (cmd_row),
    .cmd_color    (cmd_color),
    .sram_wr_en   (sram_wr_en),
    .sram_wr_addr (sram_wr_addr),
    .sram_wr_data (sram_wr_data),
    .sram_wr_ready(sram_wr_ready),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  int npass = 0;
  int ntot  = 0;
  int cyc;
  int nstall;
  int hold_bad;
  int first_cyc;
  int done_cyc;
  int err_at_done;
  logic [19:0] wa[$];
  logic [31:0] wd[$];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Presents a command in the current (IDLE) cycle T; returns in T+1.
  task automatic issue(input logic op, input logic [5:0] col,
                       input logic [4:0] row, input logic [23:0] color);
    cmd_op    = op;
    cmd_col   = col;
    cmd_row   = row;
    cmd_color = color;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    cyc = 1;
    wa.delete();
    wd.delete();
    nstall      = 0;
    hold_bad    = 0;
    first_cyc   = -1;
    done_cyc    = -1;
    err_at_done = 0;
  endtask

  // Samples each cycle until done, max_wr writes seen, or time-out.
  task automatic collect(input bit stall, input int max_wr);
    logic stalled;
    logic [19:0] pa;
    logic [31:0] pd;
    stalled = 1'b0;
    pa = '0;
    pd = '0;
    while (cyc < 6000) begin
      sram_wr_ready = stall ? (cyc % 3 != 0) : 1'b1;
      if (stalled && (sram_wr_addr !== pa || sram_wr_data !== pd))
        hold_bad++;
      stalled = sram_wr_en && !sram_wr_ready;
      pa = sram_wr_addr;
      pd = sram_wr_data;
      if (stalled) nstall++;
      if (sram_wr_en && sram_wr_ready) begin
        if (first_cyc < 0) first_cyc = cyc;
        wa.push_back(sram_wr_addr);
        wd.push_back(sram_wr_data);
      end
      if (done) begin
        done_cyc    = cyc;
        err_at_done = int'(err);
        break;
      end
      if (wa.size() == max_wr) break;
      step();
    end
    sram_wr_ready = 1'b1;
  endtask

  // Expected address of write i: base + line*800 + x, with span width w.
  task automatic seq_check(input string tag, input int base, input int w,
                           input logic [31:0] data);
    int abad;
    int dbad;
    abad = 0;
    dbad = 0;
    foreach (wa[i]) begin
      if (wa[i] !== 20'(base + (i / w) * 800 + (i % w))) abad++;
      if (wd[i] !== data) dbad++;
    end
    chk({tag, "_addr_seq_bad"}, 32'(abad), 32'd0);
    chk({tag, "_data_bad"}, 32'(dbad), 32'd0);
  endtask

  initial begin
    int dseen;
    rst_n         = 1'b0;
    cmd_valid     = 1'b1;
    cmd_op        = 1'b0;
    cmd_col       = 6'd0;
    cmd_row       = 5'd0;
    cmd_color     = 24'hABCDEF;
    sram_wr_ready = 1'b1;
    cyc           = 0;
    step();
    step();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_wr_en", 32'(sram_wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_addr", 32'(sram_wr_addr), 32'd0);
    chk("rst_data", sram_wr_data, 32'd0);
    cmd_valid = 1'b0;
    rst_n     = 1'b1;
    step();
    chk("no_accept_in_reset", 32'(busy), 32'd0);

    // Fill tile (1,0) red.
    issue(1'b0, 6'd1, 5'd0, 24'hFF0000);
    chk("f1_setup_busy", 32'(busy), 32'd1);
    chk("f1_setup_ready", 32'(cmd_ready), 32'd0);
    collect(1'b0, -1);
    chk("f1_count", 32'(wa.size()), 32'd400);
    chk("f1_first_cyc", 32'(first_cyc), 32'd2);
    chk("f1_done_cyc", 32'(done_cyc), 32'd402);
    chk("f1_err", 32'(err_at_done), 32'd0);
    if (wa.size() == 400) begin
      chk("f1_first_addr", 32'(wa[0]), 32'd20);
      chk("f1_first_data", wd[0], 32'h00FF0000);
      chk("f1_line0_end", 32'(wa[19]), 32'd39);
      chk("f1_line1_start", 32'(wa[20]), 32'd820);
      chk("f1_last_addr", 32'(wa[399]), 32'd15239);
    end
    seq_check("f1", 20, 20, 32'h00FF0000);
    chk("f1_done_wr_en", 32'(sram_wr_en), 32'd0);
    step();
    chk("f1_ready_after", 32'(cmd_ready), 32'd1);
    chk("f1_done_low", 32'(done), 32'd0);

    // Bottom-right tile.
    issue(1'b0, 6'd39, 5'd29, 24'h00FF00);
    collect(1'b0, -1);
    chk("f2_count", 32'(wa.size()), 32'd400);
    chk("f2_done_cyc", 32'(done_cyc), 32'd402);
    if (wa.size() == 400) begin
      chk("f2_first_addr", 32'(wa[0]), 32'd464780);
      chk("f2_last_addr", 32'(wa[399]), 32'd479999);
    end
    seq_check("f2", 464780, 20, 32'h0000FF00);
    step();

    // Out-of-range column.
    issue(1'b0, 6'd40, 5'd0, 24'h0000FF);
    collect(1'b0, -1);
    chk("oor_count", 32'(wa.size()), 32'd0);
    chk("oor_done_cyc", 32'(done_cyc), 32'd2);
    chk("oor_err", 32'(err_at_done), 32'd1);
    chk("oor_ready_in_done", 32'(cmd_ready), 32'd0);
    step();
    chk("oor_ready_t3", 32'(cmd_ready), 32'd1);
    chk("oor_err_low", 32'(err), 32'd0);

    // Tile (0,0) with back-pressure.
    issue(1'b0, 6'd0, 5'd0, 24'h123456);
    collect(1'b1, -1);
    chk("st_count", 32'(wa.size()), 32'd400);
    chk("st_hold_bad", 32'(hold_bad), 32'd0);
    chk("st_had_stalls", 32'(nstall > 0), 32'd1);
    chk("st_done_cyc", 32'(done_cyc), 32'(402 + nstall));
    seq_check("st", 0, 20, 32'h00123456);
    step();

    // Clear screen: check the first 2000 writes, poke a command mid-way.
    issue(1'b1, 6'd5, 5'd5, 24'hFFFFFF);
    collect(1'b0, 1000);
    cmd_op    = 1'b0;
    cmd_col   = 6'd3;
    cmd_row   = 5'd3;
    cmd_color = 24'h777777;
    cmd_valid = 1'b1;
    chk("clr_ready_mid", 32'(cmd_ready), 32'd0);
    chk("clr_busy_mid", 32'(busy), 32'd1);
    step();
    collect(1'b0, 2000);
    cmd_valid = 1'b0;
    chk("clr_count", 32'(wa.size()), 32'd2000);
    chk("clr_no_done", 32'(done_cyc), 32'hFFFFFFFF);
    chk("clr_first_cyc", 32'(first_cyc), 32'd2);
    seq_check("clr", 0, 800, 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Reset during the 100th write of a fill.
    issue(1'b0, 6'd2, 5'd3, 24'h654321);
    collect(1'b0, 100);
    chk("ab_count", 32'(wa.size()), 32'd100);
    if (wa.size() == 100)
      chk("ab_100th_addr", 32'(wa[99]), 32'd51259);
    rst_n = 1'b0;
    step();
    chk("ab_wr_en", 32'(sram_wr_en), 32'd0);
    chk("ab_ready", 32'(cmd_ready), 32'd1);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    dseen = 0;
    repeat (3) begin
      step();
      if (done || sram_wr_en) dseen++;
    end
    chk("ab_quiet", 32'(dseen), 32'd0);

    issue(1'b0, 6'd0, 5'd1, 24'h0F0F0F);
    collect(1'b0, -1);
    chk("nf_count", 32'(wa.size()), 32'd400);
    chk("nf_done_cyc", 32'(done_cyc), 32'd402);
    if (wa.size() == 400)
      chk("nf_first_addr", 32'(wa[0]), 32'd16000);
    seq_check("nf", 16000, 20, 32'h000F0F0F);
    step();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/maze_tile_blitter.md
Name: maze_tile_blitter

Overview:
- Command-driven framebuffer writer sitting directly upstream of the render stage.
- Accepts "fill one maze tile" or "clear screen" commands from game logic and converts each into a stream of single-pixel SRAM writes.
- Drives the render stage's sram_wr_en / sram_wr_addr / sram_wr_data inputs.
- Framebuffer: 800x600, one pixel per 32-bit word, word address = y*H_RES + x.

Parameters:
- H_RES, 800, visible pixels per line (framebuffer pitch in words)
- V_RES, 600, visible lines
- TILE_W, 20, tile width in pixels
- TILE_H, 20, tile height in pixels
- GRID_W, 40, tiles per row (H_RES/TILE_W)
- GRID_H, 30, tiles per column (V_RES/TILE_H)

Ports:
- clk  in  1  system clock (same clock as the SRAM controller)
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  1  0 = fill tile, 1 = clear screen
- cmd_col  in  6  tile column (fill only)
- cmd_row  in  5  tile row (fill only)
- cmd_color  in  24  {R,G,B} fill colour
- sram_wr_en  out  1  write request to render/SRAM path
- sram_wr_addr  out  20  word address
- sram_wr_data  out  32  {8'h00, R, G, B}
- sram_wr_ready  in  1  write accepted this cycle
- busy  out  1  command in progress
- done  out  1  one-cycle pulse when a command completes
- err  out  1  valid only with done; 1 = out-of-range tile, nothing written

Behaviour:
- Reset: synchronous on clk edge while rst_n=0.
  - All outputs 0 except cmd_ready=1.
  - FSM returns to IDLE from any state; an in-flight command is abandoned (partial tile is not completed or undone).
- FSM states: IDLE, SETUP, WRITE, FINISH.
- IDLE:
  - cmd_ready=1, busy=0.
  - When cmd_valid & cmd_ready, latch op/col/row/color and go to SETUP.
- SETUP (one cycle):
  - cmd_ready=0, busy=1.
  - Fill: base = row*TILE_H*H_RES + col*TILE_W.
  - Clear: base = 0, colour forced to 24'h000000.
  - Fill with col>=GRID_W or row>=GRID_H: go to FINISH with err=1 and issue no writes.
  - Otherwise go to WRITE.
- WRITE:
  - sram_wr_en=1; sram_wr_addr and sram_wr_data held stable until a cycle with sram_wr_ready=1.
  - On an accepted write, advance x within the span:
    - Fill span: TILE_W x TILE_H.
    - Clear span: H_RES x V_RES.
  - End of a line: addr += H_RES - span_w + 1. Otherwise addr += 1.
  - Address is computed incrementally; no per-pixel multiply.
  - After the last accepted write, deassert sram_wr_en in the next cycle and go to FINISH.
- FINISH (one cycle):
  - done=1; err as determined in SETUP; busy=1.
  - Next state IDLE; cmd_ready rises the cycle after done.
- Latency, fill with ready tied high:
  - Handshake in cycle T; first write in T+2.
  - 400 writes in T+2..T+401; done in T+402.
- Latency, clear with ready tied high: 480000 writes, done at T+480002.
- Backpressure: each cycle with sram_wr_ready=0 during WRITE adds exactly one cycle. No address skip, no duplicate write.
- cmd_valid while busy: ignored (cmd_ready=0). The command must be held by the source until accepted.
- Commands arriving on the reset-release cycle are not accepted.
- Address width: 20 bits; maximum address 479999, which never wraps.
- sram_wr_data[31:24] is always 0.

Test Plan:
- Reset, then fill col=1, row=0, color=24'hFF0000, ready=1:
  - first write addr 20, data 32'h00FF0000;
  - line 0 covers addrs 20..39, line 1 starts at 820;
  - last write addr 15239;
  - exactly 400 writes; done at T+402, err=0.
- Fill col=39, row=29, color=24'h00FF00 → first addr 464780, last addr 479999, 400 writes.
- Fill col=40, row=0 → zero sram_wr_en cycles; done with err=1 at T+2; cmd_ready=1 at T+3.
- Fill tile (0,0) with sram_wr_ready low on every 3rd cycle:
  - address/data held stable during stalls;
  - 400 distinct addresses in increasing row-major order;
  - done delayed by exactly the number of stall cycles.
- Clear screen → 480000 writes, all data 0, addresses 0..479999 contiguous; cmd_valid pulsed mid-clear is ignored.
- rst_n low during the 100th write of a fill:
  - next cycle sram_wr_en=0, cmd_ready=1, busy=0, no done pulse;
  - a new fill command is then accepted normally.
